fir4_avg_decim_out: RTL and testbench

//  Downstream stage of the 4-tap unsigned averaging FIR. Takes the raw (w+2)-bit tap sum s.

---
 rtl/fir_avg_pkg.sv | 27 ++
 rtl/sync_fifo_u.sv | 50 +++++
 rtl/fir4_avg_decim_out.sv | 75 +++++++
 tb/tb_fir4_avg_decim_out.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fir_avg_pkg.sv
// Shared constants and the divide-by-taps helper for the averaging FIR tail.
// FIR_AVG_ROUND_EN selects round-half-up averaging; default truncates.
package fir_avg_pkg;

  localparam int TAPS = 4;
  localparam int MAX_W = 32;
  localparam int DEPTH_DEF = 4;

  typedef logic [$clog2(DEPTH_DEF):0] lvl_t;

  function automatic logic [MAX_W-1:0] avg_of(
    input logic [MAX_W+1:0] s,
    input int               w
  );
    logic [MAX_W+1:0] lim;
    logic [MAX_W+1:0] t;
    lim = (MAX_W+2)'((64'd1 << w) - 64'd1);
    t = s >> $clog2(TAPS);
`ifdef FIR_AVG_ROUND_EN
    // clamp only matters for sums above TAPS*(2^w-1)
    if (s[$clog2(TAPS)-1] && t < lim)
      t = t + (MAX_W+2)'(1);
`endif
    return MAX_W'(t & lim);
  endfunction

endpackage

// File: rtl/sync_fifo_u.sv
// Plain synchronous FIFO, async active-high reset, head shown as 0 when empty.
// Pointers carry one wrap bit so full and empty are distinguishable.
module sync_fifo_u #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign level = wp - rp;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir4_avg_decim_out.sv
// FIR tail: /4 average, warm-up discard, decimate by D, buffer, valid/ready out.
// Build with FIR_AVG_ROUND_EN for round-half-up; default truncates.
module fir4_avg_decim_out
  import fir_avg_pkg::*;
#(
  parameter int w      = 16,
  parameter int D      = 2,
  parameter int WARMUP = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [w+1:0]             s,
  input  logic                     s_valid,
  output logic [w-1:0]             avg,
  output logic                     avg_valid,
  input  logic                     avg_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP+1) : 1;
  localparam int DCW = (D > 1) ? $clog2(D) : 1;

  logic [WCW-1:0] wcnt;
  logic [DCW-1:0] dcnt;
  logic           warm;
  logic           kept;
  logic           pop;
  logic           push;
  logic           drop;
  logic           full;
  logic           empty;
  logic [w-1:0]   avg_in;

  assign warm = (wcnt == WCW'(WARMUP));
  assign kept = s_valid && warm && (dcnt == '0);
  assign avg_valid = !empty;
  assign pop  = avg_valid && avg_ready;
  assign push = kept && (!full || pop);
  assign drop = kept && full && !pop;

  assign avg_in = w'(avg_of((MAX_W+2)'(s), w));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
      dcnt <= '0;
      ovf  <= 1'b0;
    end else begin
      if (s_valid && !warm)
        wcnt <= wcnt + 1'b1;
      if (s_valid && warm)
        dcnt <= (dcnt == DCW'(D-1)) ? '0 : dcnt + 1'b1;
      if (drop)
        ovf <= 1'b1;
    end
  end

  sync_fifo_u #(
    .W     (w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (avg_in),
    .pop   (pop),
    .dout  (avg),
    .empty (empty),
    .full  (full),
    .level (level)
  );

endmodule

// File: tb/tb_fir4_avg_decim_out.sv
// Directed bench for fir4_avg_decim_out (w=16, D=2, WARMUP=4, DEPTH=4).
// Expectations follow FIR_AVG_ROUND_EN when the bench is built with it.
module tb_fir4_avg_decim_out;

`ifdef FIR_AVG_ROUND_EN
  localparam int R6 = 2;
`else
  localparam int R6 = 1;
`endif

  logic        clk;
  logic        reset;
  logic [17:0] s;
  logic        s_valid;
  logic [15:0] avg;
  logic        avg_valid;
  logic        avg_ready;
  logic [2:0]  level;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  fir4_avg_decim_out #(
    .w(16), .D(2), .WARMUP(4), .DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s         (s),
    .s_valid   (s_valid),
    .avg       (avg),
    .avg_valid (avg_valid),
    .avg_ready (avg_ready),
    .level     (level),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    s = '0;
    avg_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic warm_up();
    s_valid = 1'b1;
    s = '0;
    repeat (4) tick();
  endtask

  // one kept sample, then one sample the decimator skips
  task automatic pair(input int v);
    s_valid = 1'b1;
    s = 18'(v);
    tick();
    s = '0;
    tick();
  endtask

  task automatic chk_out(input string tag, input int v, input int a);
    chk({tag, ".valid"}, int'(avg_valid), v);
    chk({tag, ".avg"}, int'(avg), a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s = '0;
    s_valid = 1'b0;
    avg_ready = 1'b0;
    #2;
    chk_out("rst", 0, 0);
    chk("rst.level", int'(level), 0);
    chk("rst.ovf", int'(ovf), 0);
    tick();
    reset = 1'b0;

    // warm-up
    s_valid = 1'b1;
    s = 18'd40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wu.valid", int'(avg_valid), 0);
    end
    s = 18'd400;
    tick();
    chk_out("wu.first", 1, 100);
    chk("wu.level", int'(level), 1);

    // decimation
    do_reset();
    warm_up();
    avg_ready = 1'b1;
    s = 18'd8;  tick(); chk_out("dec.8", 1, 2);
    s = 18'd12; tick(); chk_out("dec.12", 0, 0);
    s = 18'd16; tick(); chk_out("dec.16", 1, 4);
    s = 18'd20; tick(); chk_out("dec.20", 0, 0);

    // rounding / width
    do_reset();
    warm_up();
    avg_ready = 1'b1;
    s = 18'd6; tick(); chk_out("rnd.6", 1, R6);
    s = 18'd0; tick(); chk_out("rnd.skip", 0, 0);
    s = 18'h3FFFF; tick(); chk_out("rnd.max", 1, 16'hFFFF);

    // overflow
    do_reset();
    warm_up();
    for (int i = 1; i <= 4; i++) pair(4 * i);
    chk("ovf.l4", int'(level), 4);
    chk("ovf.pre", int'(ovf), 0);
    pair(20);
    chk("ovf.l5", int'(level), 4);
    chk("ovf.set", int'(ovf), 1);
    s_valid = 1'b0;
    avg_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk_out("ovf.pop", 1, i);
      tick();
    end
    chk_out("ovf.empty", 0, 0);
    chk("ovf.level0", int'(level), 0);
    chk("ovf.sticky", int'(ovf), 1);

    // full + simultaneous pop
    do_reset();
    warm_up();
    for (int i = 1; i <= 4; i++) pair(4 * i);
    avg_ready = 1'b1;
    s = 18'd20;
    tick();
    chk("fp.level", int'(level), 4);
    chk("fp.ovf", int'(ovf), 0);
    s_valid = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      chk_out("fp.pop", 1, i);
      tick();
    end
    chk_out("fp.empty", 0, 0);

    // async reset mid-stream
    do_reset();
    warm_up();
    for (int i = 1; i <= 5; i++) pair(4 * i);
    s_valid = 1'b0;
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
    chk("ar.l3", int'(level), 3);
    chk("ar.ovf1", int'(ovf), 1);
    #3;
    reset = 1'b1;
    #1;
    chk_out("ar.now", 0, 0);
    chk("ar.level", int'(level), 0);
    chk("ar.ovf", int'(ovf), 0);
    tick();
    reset = 1'b0;
    s_valid = 1'b1;
    s = 18'd40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar.wu", int'(avg_valid), 0);
    end
    s = 18'd400;
    tick();
    chk_out("ar.first", 1, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
